// File: rtl/mag_window_stats.sv
// Sliding-window statistics on magnitude samples: moving average over the last
// DEPTH samples, peak/min since clear, and a sticky over-threshold alarm.
module mag_window_stats #(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     thresh,
    output logic [DATA_W-1:0]     avg_out,
    output logic                  avg_valid,
    output logic [DATA_W-1:0]     peak_out,
    output logic [DATA_W-1:0]     min_out,
    output logic                  alarm,
    output logic [LOG2_DEPTH:0]   fill_count
);

    // state   | meaning
    // EMPTY   | no samples held since reset/clear
    // FILLING | 1..DEPTH-1 samples held, average not yet valid
    // FULL    | window holds DEPTH samples, avg_valid asserted

    localparam int DEPTH  = 1 << LOG2_DEPTH;
    localparam int SUM_W  = DATA_W + LOG2_DEPTH;
    localparam int FILL_W = LOG2_DEPTH + 1;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

    state_t                  state;
    logic [DATA_W-1:0]       sample_buf [DEPTH];
    logic [SUM_W-1:0]        sum;
    logic [SUM_W-1:0]        sum_new;
    logic [LOG2_DEPTH-1:0]   wr_ptr;
    logic                    alarm_cond;

    // Evicted slot is zero while filling, so one update rule covers every state.
    assign sum_new    = sum + SUM_W'(in_data) - SUM_W'(sample_buf[wr_ptr]);
    assign alarm_cond = avg_valid && (avg_out > thresh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sample_buf[i] <= '0;
            sum        <= '0;
            wr_ptr     <= '0;
            fill_count <= '0;
            avg_out    <= '0;
            avg_valid  <= 1'b0;
            peak_out   <= '0;
            min_out    <= '1;
            alarm      <= 1'b0;
            state      <= EMPTY;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) sample_buf[i] <= '0;
            sum        <= '0;
            wr_ptr     <= '0;
            fill_count <= '0;
            avg_out    <= '0;
            avg_valid  <= 1'b0;
            peak_out   <= '0;
            min_out    <= '1;
            alarm      <= 1'b0;
            state      <= EMPTY;
        end else begin
            alarm <= alarm | alarm_cond;
            if (in_valid) begin
                sample_buf[wr_ptr] <= in_data;
                sum                <= sum_new;
                wr_ptr             <= wr_ptr + LOG2_DEPTH'(1);
                avg_out            <= sum_new[SUM_W-1:LOG2_DEPTH];
                if (in_data > peak_out) peak_out <= in_data;
                if (in_data < min_out)  min_out  <= in_data;
                case (state)
                    EMPTY, FILLING: begin
                        fill_count <= fill_count + FILL_W'(1);
                        if (fill_count == FILL_W'(DEPTH - 1)) begin
                            state     <= FULL;
                            avg_valid <= 1'b1;
                        end else begin
                            state <= FILLING;
                        end
                    end
                    default: state <= FULL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mag_window_stats.sv
// Scoreboard bench for mag_window_stats: a queue-based window model predicts
// every cycle's outputs, a monitor compares them after each rising edge.
module tb_mag_window_stats;

    localparam int DATA_W     = 8;
    localparam int LOG2_DEPTH = 3;
    localparam int DEPTH      = 1 << LOG2_DEPTH;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                clear;
    logic [DATA_W-1:0]   thresh;
    logic [DATA_W-1:0]   avg_out;
    logic                avg_valid;
    logic [DATA_W-1:0]   peak_out;
    logic [DATA_W-1:0]   min_out;
    logic                alarm;
    logic [LOG2_DEPTH:0] fill_count;

    mag_window_stats #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .clear      (clear),
        .thresh     (thresh),
        .avg_out    (avg_out),
        .avg_valid  (avg_valid),
        .peak_out   (peak_out),
        .min_out    (min_out),
        .alarm      (alarm),
        .fill_count (fill_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int avg;
        int avgv;
        int peak;
        int mn;
        int alarm;
        int fill;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: the window is simply the last DEPTH accepted samples.
    int win[$];
    int m_avg, m_avgv, m_peak, m_min, m_alarm;

    task automatic chk(input string nm, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_avg = 0; m_avgv = 0; m_peak = 0; m_min = 255; m_alarm = 0;
    endtask

    task automatic model_step(input int v, input int d, input int c, input int t);
        int s;
        if (c != 0) begin
            model_reset();
            return;
        end
        if (m_avgv != 0 && m_avg > t) m_alarm = 1;
        if (v != 0) begin
            win.push_back(d);
            if (win.size() > DEPTH) void'(win.pop_front());
            s = 0;
            foreach (win[i]) s += win[i];
            m_avg  = s / DEPTH;
            m_avgv = (win.size() == DEPTH) ? 1 : 0;
            if (d > m_peak) m_peak = d;
            if (d < m_min)  m_min  = d;
        end
    endtask

    // Drive one cycle's inputs at the falling edge and queue the prediction.
    task automatic step(input int v, input int d, input int c, input int t);
        exp_t e;
        @(negedge clk);
        in_valid = v[0];
        in_data  = d[7:0];
        clear    = c[0];
        thresh   = t[7:0];
        model_step(v, d, c, t);
        e.avg = m_avg; e.avgv = m_avgv; e.peak = m_peak; e.mn = m_min;
        e.alarm = m_alarm; e.fill = win.size();
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_avg"},   int'(avg_out),    0);
        chk({tag, "_avgv"},  int'(avg_valid),  0);
        chk({tag, "_peak"},  int'(peak_out),   0);
        chk({tag, "_min"},   int'(min_out),    255);
        chk({tag, "_alarm"}, int'(alarm),      0);
        chk({tag, "_fill"},  int'(fill_count), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_avg",   int'(avg_out),    e.avg);
                chk("sb_avgv",  int'(avg_valid),  e.avgv);
                chk("sb_peak",  int'(peak_out),   e.peak);
                chk("sb_min",   int'(min_out),    e.mn);
                chk("sb_alarm", int'(alarm),      e.alarm);
                chk("sb_fill",  int'(fill_count), e.fill);
            end
        end
    end

    initial begin : stim
        int v, d, c, t;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; thresh = 8'd255;
        model_reset();
        #3;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i <= DEPTH; i++) begin
            step(1, i * 10, 0, 255);
            chk("fill_ramp", int'(fill_count), i);
            chk("avgv_ramp", int'(avg_valid), (i == DEPTH) ? 1 : 0);
        end
        chk("full_avg",  int'(avg_out),  45);
        chk("full_peak", int'(peak_out), 80);
        chk("full_min",  int'(min_out),  10);

        step(1, 100, 0, 255);
        chk("evict_avg",  int'(avg_out),  56);
        chk("evict_peak", int'(peak_out), 100);

        step(0, 0, 0, 56);
        chk("alarm_eq_thresh", int'(alarm), 0);
        step(0, 0, 0, 55);
        chk("alarm_set", int'(alarm), 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 200);
        chk("alarm_sticky", int'(alarm), 1);

        for (int i = 0; i < DEPTH; i++) step(1, 50, 0, 255);
        step(1, 200, 1, 255);
        chk_reset("clear_wins");
        for (int i = 0; i < DEPTH; i++) step(1, 8, 0, 255);
        chk("const8_avg", int'(avg_out), 8);

        step(0, 0, 1, 255);
        for (int i = 0; i < 3; i++) step(1, 255, 0, 255);
        chk("part_avgv", int'(avg_valid),  0);
        chk("part_avg",  int'(avg_out),    95);
        chk("part_fill", int'(fill_count), 3);
        step(1, 0, 0, 255);
        chk("part_min",  int'(min_out),  0);
        chk("part_peak", int'(peak_out), 255);

        #1 rst = 1'b1;
        #1 chk_reset("async_rst");
        rst = 1'b0;
        model_reset();
        step(1, 77, 0, 255);
        chk("post_rst_fill", int'(fill_count), 1);

        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 9) < 8) ? 1 : 0;
            case ($urandom_range(0, 3))
                0:       d = 0;
                1:       d = 255;
                default: d = $urandom_range(0, 255);
            endcase
            c = ($urandom_range(0, 59) == 0) ? 1 : 0;
            t = $urandom_range(60, 255);
            step(v, d, c, t);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
